// File: rtl/fetch_stage.sv
// Instruction fetch: PC, icache request, redirect absorption and IF/ID latch.
// Define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
module fetch_stage #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              fetch_en,
    input  logic              fdeassert,
    input  logic              ihit,
    input  logic [DATA_W-1:0] imemload,
    output logic              imemREN,
    output logic [ADDR_W-1:0] imemaddr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] npc_out,
    output logic              valid_out,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PEND,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pco_q, pco_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic              valid_q, valid_d;
    logic              load;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc   = pc_q + ADDR_W'(4);
    assign imemREN  = (state_q != S_HALT);
    assign imemaddr = pc_q;
    assign halted   = (state_q == S_HALT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        load      = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (ihit) begin
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (fetch_en) begin
                        pc_d = pc_inc;
                        load = 1'b1;
                    end
                end else if (redirect_valid) begin
                    // miss in flight: address must stay stable until ihit
                    pend_pc_d = redirect_pc;
                    state_d   = S_PEND;
                end
            end
            S_PEND: begin
                if (redirect_valid) begin
                    pend_pc_d = redirect_pc;
                end
                if (ihit) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
            end
            default: state_d = S_RUN;
        endcase
        if (halt) begin
            state_d   = S_HALT;
            pc_d      = pc_q;
            pend_pc_d = pend_pc_q;
            load      = 1'b0;
        end
    end

    always_comb begin
        instr_d = instr_q;
        pco_d   = pco_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        if (fdeassert) begin
            instr_d = '0;
            pco_d   = '0;
            npc_d   = '0;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = imemload;
            pco_d   = pc_q;
            npc_d   = pc_inc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_RUN;
            pc_q      <= PC_INIT;
            pend_pc_q <= '0;
            instr_q   <= '0;
            pco_q     <= '0;
            npc_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            instr_q   <= instr_d;
            pco_q     <= pco_d;
            npc_q     <= npc_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pco_q;
    assign npc_out   = npc_q;
    assign valid_out = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        fetched_d = fetched_q + {31'b0, load};
        stall_d   = stall_q + {31'b0, imemREN & ~ihit};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan plus randomized traffic
// against a behavioural fetch model.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        fetch_en;
    logic        fdeassert;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        valid_out;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_stage #(
        .ADDR_W (32),
        .DATA_W (32),
        .PC_INIT(32'h0000_0000)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .fetch_en      (fetch_en),
        .fdeassert     (fdeassert),
        .ihit          (ihit),
        .imemload      (imemload),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .npc_out       (npc_out),
        .valid_out     (valid_out),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // behavioural model state
    logic [31:0] m_pc, m_pend_pc, m_instr, m_pco, m_npc;
    logic [31:0] m_fetched, m_stall;
    bit          m_valid, m_halted, m_pend;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin : model
        bit          ld;
        logic [31:0] lpc;
        if (RST) begin
            m_pc      = 32'h0;
            m_pend_pc = 32'h0;
            m_pend    = 0;
            m_halted  = 0;
            m_instr   = 32'h0;
            m_pco     = 32'h0;
            m_npc     = 32'h0;
            m_valid   = 0;
            m_fetched = 32'h0;
            m_stall   = 32'h0;
        end else begin
            ld  = 0;
            lpc = m_pc;
            if (!m_halted && !ihit) m_stall = m_stall + 1;
            if (halt) begin
                m_halted = 1;
            end else if (!m_halted) begin
                if (ihit) begin
                    if (redirect_valid) m_pc = redirect_pc;
                    else if (m_pend) m_pc = m_pend_pc;
                    else if (fetch_en) begin
                        ld   = 1;
                        m_pc = m_pc + 32'd4;
                    end
                    m_pend = 0;
                end else if (redirect_valid) begin
                    m_pend    = 1;
                    m_pend_pc = redirect_pc;
                end
            end
            if (fdeassert) begin
                m_instr = 32'h0;
                m_pco   = 32'h0;
                m_npc   = 32'h0;
                m_valid = 0;
            end else if (ld) begin
                m_instr   = mem(lpc);
                m_pco     = lpc;
                m_npc     = lpc + 32'd4;
                m_valid   = 1;
                m_fetched = m_fetched + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_on) begin
            chk("imemaddr", imemaddr, m_pc);
            chk("imemREN", {31'b0, imemREN}, {31'b0, !m_halted});
            chk("halted", {31'b0, halted}, {31'b0, m_halted});
            chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
            chk("instr_out", instr_out, m_instr);
            chk("pc_out", pc_out, m_pco);
            chk("npc_out", npc_out, m_npc);
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_stall", perf_stall, m_stall);
`endif
        end
    end

    task automatic step(input bit r, input bit fe, input bit fd, input bit ih,
                        input bit rv, input logic [31:0] rp, input bit h);
        RST            = r;
        fetch_en       = fe;
        fdeassert      = fd;
        ihit           = ih;
        redirect_valid = rv;
        redirect_pc    = rp;
        halt           = h;
        imemload       = ih ? mem(m_pc) : $urandom;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 32'h0, 0);
        chk_on = 1'b1;
        step(1, 0, 0, 0, 0, 32'h0, 0);
        chk("rst imemaddr", imemaddr, 32'h0);
        chk("rst valid", {31'b0, valid_out}, 32'h0);
        chk("rst instr", instr_out, 32'h0);
        chk("rst halted", {31'b0, halted}, 32'h0);

        step(0, 1, 0, 1, 0, 32'h0, 0);
        chk("seq addr 4", imemaddr, 32'h4);
        step(0, 1, 0, 1, 0, 32'h0, 0);
        chk("seq addr 8", imemaddr, 32'h8);
        step(0, 1, 0, 1, 0, 32'h0, 0);
        chk("seq instr@8", instr_out, mem(32'h8));
        chk("seq pc_out", pc_out, 32'h8);
        chk("seq npc_out", npc_out, 32'hC);
        chk("seq valid", {31'b0, valid_out}, 32'h1);

        step(0, 0, 0, 1, 1, 32'h40, 0);
        chk("redir addr", imemaddr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 32'h0, 0);
            chk("miss hold", imemaddr, 32'h40);
        end
        step(0, 1, 0, 1, 0, 32'h0, 0);
        chk("miss instr", instr_out, mem(32'h40));
        chk("miss pc_out", pc_out, 32'h40);

        step(0, 1, 1, 1, 1, 32'h40, 0);
        chk("flush valid", {31'b0, valid_out}, 32'h0);
        step(0, 1, 0, 0, 1, 32'h100, 0);
        step(0, 1, 0, 0, 1, 32'h200, 0);
        chk("pend hold", imemaddr, 32'h40);
        step(0, 1, 0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 1, 0, 32'h0, 0);
        chk("pend drop", {31'b0, valid_out}, 32'h0);
        chk("pend latest", imemaddr, 32'h200);

        step(0, 1, 0, 1, 0, 32'h0, 0);
        chk("load valid", {31'b0, valid_out}, 32'h1);
        step(0, 0, 1, 1, 0, 32'h0, 0);
        chk("fd valid", {31'b0, valid_out}, 32'h0);
        chk("fd instr", instr_out, 32'h0);
        chk("fd pc", imemaddr, 32'h204);

        step(0, 1, 0, 1, 1, 32'h300, 1);
        chk("halt pc", imemaddr, 32'h204);
        chk("halt ren", {31'b0, imemREN}, 32'h0);
        chk("halt flag", {31'b0, halted}, 32'h1);
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 1, 1, 32'h500, 0);
        chk("halt sticky", {31'b0, halted}, 32'h1);
        chk("halt frozen", imemaddr, 32'h204);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        chk("unhalt pc", imemaddr, 32'h0);
        chk("unhalt flag", {31'b0, halted}, 32'h0);

        step(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0);
        step(0, 1, 0, 1, 0, 32'h0, 0);
        chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap npc_out", npc_out, 32'h0);
        chk("wrap pc", imemaddr, 32'h0);

`ifdef FETCH_PERF_EN
        step(1, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 32'h0, 0);
        chk("perf fetched", perf_fetched, 32'd5);
        chk("perf stall", perf_stall, 32'd3);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        chk("perf clr f", perf_fetched, 32'd0);
        chk("perf clr s", perf_stall, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            if ($urandom_range(3) == 0)
                rp = 32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2);
            else
                rp = $urandom & 32'hFFFF_FFFC;
            step($urandom_range(199) == 0, $urandom_range(3) != 0,
                 $urandom_range(9) == 0, $urandom_range(9) < 6,
                 $urandom_range(5) == 0, rp, $urandom_range(399) == 0);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
